// File: rtl/pa_spsram_512x38_ctrl.sv
// -----------------------------------------------------------------------------
// pa_spsram_512x38_ctrl
//
// Access controller for the LSU 512x38 single-port SRAM wrapper. It is the
// only driver of the SRAM pins. It converts a valid/ready request interface
// into the macro's active-low CEN/GWEN/WEN strobes and returns read data as a
// one-cycle response pulse. After every reset, and whenever init_req is
// pulsed while idle, a hardware sweep writes INIT_VALUE to every entry.
//
// Optional build macro:
//   PA_SPSRAM_CTRL_RDATA_FLOP_EN
//     defined   : sram_q is registered before rsp_data (read latency 2)
//     undefined : rsp_data comes straight from sram_q  (read latency 1)
//
// Parameters:
//   ADDR_WIDTH  SRAM address width, depth = 2**ADDR_WIDTH
//   DATA_WIDTH  data / bit-mask width
//   INIT_VALUE  word written to every entry during the init sweep
//
// Ports:
//   forever_cpuclk  in   clock (only clock)
//   cpurst_b        in   asynchronous active-low reset
//   req_vld         in   request valid
//   req_rdy         out  request accepted when req_vld & req_rdy
//   req_wr          in   1 = write, 0 = read
//   req_addr        in   entry index
//   req_wdata       in   write data
//   req_wmask       in   active-high per-bit write enable
//   rsp_vld         out  one-cycle read-data-valid pulse
//   rsp_data        out  read data, meaningful only while rsp_vld = 1
//   init_req        in   pulse; starts an init sweep from IDLE
//   init_busy       out  high while the sweep runs
//   sram_a          out  SRAM address
//   sram_cen        out  SRAM chip enable, active-low
//   sram_gwen       out  SRAM global write enable, active-low
//   sram_wen        out  SRAM per-bit write enable, active-low
//   sram_d          out  SRAM write data
//   sram_q          in   SRAM read data, valid one cycle after a read strobe
// -----------------------------------------------------------------------------
module pa_spsram_512x38_ctrl #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 38,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  // request / response
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  // init control
  input  logic                  init_req,
  output logic                  init_busy,
  // SRAM macro side
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  // Last address / data put on the SRAM pins; replayed on idle cycles so the
  // macro inputs do not toggle when nothing is accessed.
  logic [ADDR_WIDTH-1:0] r_a_hold;
  logic [DATA_WIDTH-1:0] r_d_hold;
  logic                  r_rsp_vld;

  // ---------------------------------------------------------------------------
  // Combinational next-state / output decode
  // ---------------------------------------------------------------------------
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] w_cnt_next;
  logic                  w_req_rdy;
  logic                  w_rd_acc;
  logic                  w_cen;
  logic                  w_gwen;
  logic [DATA_WIDTH-1:0] w_wen;
  logic [ADDR_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_d;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_req_rdy    = 1'b0;
    w_rd_acc     = 1'b0;
    w_cen        = 1'b1;
    w_gwen       = 1'b1;
    w_wen        = '1;
    w_a          = r_a_hold;
    w_d          = r_d_hold;

    unique case (r_state)
      ST_INIT: begin
        // Full-word write of INIT_VALUE to entry cnt every cycle. init_req is
        // deliberately ignored here so a running sweep never restarts.
        w_cen  = 1'b0;
        w_gwen = 1'b0;
        w_wen  = '0;
        w_a    = r_cnt;
        w_d    = INIT_VALUE;
        if (r_cnt == CNT_MAX) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_IDLE: begin
        // init_req has priority: a coincident request is simply not accepted.
        w_req_rdy = ~init_req;
        if (init_req) begin
          w_state_next = ST_INIT;
          w_cnt_next   = '0;
        end else if (req_vld) begin
          w_cen = 1'b0;
          w_a   = req_addr;
          if (req_wr) begin
            // An all-zero mask still strobes the macro but as a non-writing
            // access (gwen high, wen all high), so it behaves as a no-op.
            w_gwen = ~(|req_wmask);
            w_wen  = ~req_wmask;
            w_d    = req_wdata;
          end else begin
            w_rd_acc = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = ST_INIT;
        w_cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_a_hold <= '0;
      r_d_hold <= INIT_VALUE;
    end else begin
      r_a_hold <= w_a;
      r_d_hold <= w_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read response path
  // ---------------------------------------------------------------------------
`ifdef PA_SPSRAM_CTRL_RDATA_FLOP_EN
  // Two-stage path: r_rd_pend marks the cycle sram_q is valid, which is then
  // captured into r_rsp_data. The pipeline is never flushed by init_req, so
  // reads in flight still deliver their pulse during the following sweep.
  logic                  r_rd_pend;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rd_pend  <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_rd_pend <= w_rd_acc;
      r_rsp_vld <= r_rd_pend;
      if (r_rd_pend) begin
        r_rsp_data <= sram_q;
      end
    end
  end

  assign rsp_data = r_rsp_data;
`else
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rsp_vld <= 1'b0;
    end else begin
      r_rsp_vld <= w_rd_acc;
    end
  end

  // Gated so rsp_data reads as zero out of reset and between pulses.
  assign rsp_data = r_rsp_vld ? sram_q : '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rsp_vld   = r_rsp_vld;
  assign req_rdy   = w_req_rdy;
  assign init_busy = (r_state == ST_INIT);
  assign sram_cen  = w_cen;
  assign sram_gwen = w_gwen;
  assign sram_wen  = w_wen;
  assign sram_a    = w_a;
  assign sram_d    = w_d;

endmodule

// File: tb/tb_pa_spsram_512x38_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pa_spsram_512x38_ctrl
//
// Directed bench for pa_spsram_512x38_ctrl with a behavioural 512x38 SRAM
// attached to the sram_* pins. Inputs change on the falling edge; outputs are
// sampled 1 ns later, well away from the rising (active) edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pa_spsram_512x38_ctrl;

  localparam int AW = 9;
  localparam int DW = 38;
`ifdef PA_SPSRAM_CTRL_RDATA_FLOP_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst_b;
  logic          req_vld;
  logic          req_rdy;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_wmask;
  logic          rsp_vld;
  logic [DW-1:0] rsp_data;
  logic          init_req;
  logic          init_busy;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int tests = 0;
  int fails = 0;

  pa_spsram_512x38_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .rsp_vld        (rsp_vld),
    .rsp_data       (rsp_data),
    .init_req       (init_req),
    .init_busy      (init_busy),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM: active-low strobes, bit-masked write,
  // q updated only by reads and valid the cycle after the strobe.
  logic [DW-1:0] mem [512];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 38'h2A_AAAA_AAAA;
    sram_q = '0;
  end
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  // Stimulus-only helpers (no checking inside).
  task automatic drive_idle();
    req_vld = 1'b0; req_wr = 1'b0; init_req = 1'b0;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] m);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = a;
  endtask

  // Checks a full sweep starting in the current cycle (which must be cnt=0)
  // and the IDLE state that follows it.
  task automatic test_sweep_from_zero(input string tag);
    for (int i = 0; i < 512; i++) begin
      tests++;
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 ||
          sram_a !== AW'(i) || sram_d !== '0 || init_busy !== 1'b1 ||
          req_rdy !== 1'b0 || rsp_vld !== 1'b0) begin
        fails++;
        $display("FAIL %s sweep cycle %0d: cen=%b gwen=%b wen=%h a=%h d=%h busy=%b rdy=%b rsp_vld=%b, required cen=0 gwen=0 wen=0 a=%h d=0 busy=1 rdy=0 rsp_vld=0",
                 tag, i, sram_cen, sram_gwen, sram_wen, sram_a, sram_d, init_busy, req_rdy, rsp_vld, AW'(i));
      end
      @(negedge clk); #1;
    end
    tests++;
    if (init_busy !== 1'b0 || req_rdy !== 1'b1 || sram_cen !== 1'b1) begin
      fails++;
      $display("FAIL %s sweep end: busy=%b rdy=%b cen=%b, required busy=0 rdy=1 cen=1",
               tag, init_busy, req_rdy, sram_cen);
    end
    $display("[TB] %s: sweep of 512 cycles checked", tag);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    tests++;
    if (req_rdy !== 1'b0 || init_busy !== 1'b1 || rsp_vld !== 1'b0 || rsp_data !== '0 ||
        sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 || sram_a !== '0 || sram_d !== '0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b busy=%b rsp_vld=%b rsp_data=%h cen=%b gwen=%b wen=%h a=%h d=%h, required 0 1 0 0 0 0 0 0 0",
               req_rdy, init_busy, rsp_vld, rsp_data, sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
    end
    $display("[TB] reset values checked");
    @(negedge clk); rst_b = 1'b1; #1;
    test_sweep_from_zero("reset_release");
  endtask

  task automatic test_write_read();
    for (int s = 0; s <= LAT + 2; s++) begin
      @(negedge clk);
      if (s == 0)      drive_write(9'h1FF, 38'h3F_FFFF_FFFF, '1);
      else if (s == 1) drive_read(9'h1FF);
      else             drive_idle();
      #1;
      if (s == 0) begin
        tests++;
        if (req_rdy !== 1'b1 || sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 ||
            sram_a !== 9'h1FF || sram_d !== 38'h3F_FFFF_FFFF) begin
          fails++;
          $display("FAIL write_strobe: rdy=%b cen=%b gwen=%b wen=%h a=%h d=%h, required 1 0 0 0 1ff 3fffffffff",
                   req_rdy, sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
        end
      end else if (s == 1) begin
        tests++;
        if (sram_cen !== 1'b0 || sram_gwen !== 1'b1 || sram_wen !== '1 || sram_a !== 9'h1FF || rsp_vld !== 1'b0) begin
          fails++;
          $display("FAIL read_strobe: cen=%b gwen=%b wen=%h a=%h rsp_vld=%b, required 0 1 3fffffffff 1ff 0",
                   sram_cen, sram_gwen, sram_wen, sram_a, rsp_vld);
        end
      end else begin
        tests++;
        if (s == 1 + LAT) begin
          if (rsp_vld !== 1'b1 || rsp_data !== 38'h3F_FFFF_FFFF) begin
            fails++;
            $display("FAIL write_read_rsp: rsp_vld=%b rsp_data=%h, required 1 3fffffffff", rsp_vld, rsp_data);
          end
        end else if (rsp_vld !== 1'b0) begin
          fails++;
          $display("FAIL write_read_no_rsp step %0d: rsp_vld=%b, required 0", s, rsp_vld);
        end
        // Idle cycle: strobes off, address/data parked at last driven values.
        tests++;
        if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== '1 ||
            sram_a !== 9'h1FF || sram_d !== 38'h3F_FFFF_FFFF) begin
          fails++;
          $display("FAIL idle_hold step %0d: cen=%b gwen=%b wen=%h a=%h d=%h, required 1 1 3fffffffff 1ff 3fffffffff",
                   s, sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
        end
      end
    end
    $display("[TB] write/read 0x1ff checked");
  endtask

  task automatic test_partial_write();
    @(negedge clk); drive_write(9'h055, 38'h3F_FFFF_FF00, '1); #1;
    @(negedge clk); drive_write(9'h055, 38'h12, 38'h00_0000_00FF); #1;
    tests++;
    if (sram_wen !== 38'h3F_FFFF_FF00 || sram_gwen !== 1'b0 || sram_cen !== 1'b0 || sram_d !== 38'h12) begin
      fails++;
      $display("FAIL partial_wen: wen=%h gwen=%b cen=%b d=%h, required 3fffffff00 0 0 12",
               sram_wen, sram_gwen, sram_cen, sram_d);
    end
    // Zero mask: strobed but non-writing; entry must stay unchanged.
    @(negedge clk); drive_write(9'h055, 38'h0, 38'h0); #1;
    tests++;
    if (sram_cen !== 1'b0 || sram_gwen !== 1'b1 || sram_wen !== '1 || rsp_vld !== 1'b0) begin
      fails++;
      $display("FAIL zero_mask_write: cen=%b gwen=%b wen=%h rsp_vld=%b, required 0 1 3fffffffff 0",
               sram_cen, sram_gwen, sram_wen, rsp_vld);
    end
    @(negedge clk); drive_read(9'h055); #1;
    @(negedge clk); drive_idle(); #1;
    for (int k = 1; k < LAT; k++) begin @(negedge clk); #1; end
    tests++;
    if (rsp_vld !== 1'b1 || rsp_data !== 38'h3F_FFFF_FF12) begin
      fails++;
      $display("FAIL partial_read: rsp_vld=%b rsp_data=%h, required 1 3fffffff12", rsp_vld, rsp_data);
    end
    $display("[TB] partial write to 0x055 checked");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_q [3];
    exp_q[0] = 38'h11_1111_1111;
    exp_q[1] = 38'h22_2222_2222;
    exp_q[2] = 38'h0C_AFE0_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_write(AW'(i), exp_q[i], '1); #1;
    end
    for (int s = 0; s < 3 + LAT + 1; s++) begin
      @(negedge clk);
      if (s < 3) drive_read(AW'(s));
      else       drive_idle();
      #1;
      tests++;
      if (s >= LAT && s < LAT + 3) begin
        if (rsp_vld !== 1'b1 || rsp_data !== exp_q[s-LAT]) begin
          fails++;
          $display("FAIL b2b_read entry %0d: rsp_vld=%b rsp_data=%h, required 1 %h",
                   s - LAT, rsp_vld, rsp_data, exp_q[s-LAT]);
        end
      end else if (rsp_vld !== 1'b0) begin
        fails++;
        $display("FAIL b2b_no_rsp step %0d: rsp_vld=%b, required 0", s, rsp_vld);
      end
    end
    $display("[TB] back-to-back reads of 0,1,2 checked");
  endtask

  task automatic test_init_collision();
    @(negedge clk); drive_read(9'h001); init_req = 1'b1; #1;
    tests++;
    if (req_rdy !== 1'b0 || sram_cen !== 1'b1 || init_busy !== 1'b0) begin
      fails++;
      $display("FAIL collision_accept: rdy=%b cen=%b busy=%b, required 0 1 0", req_rdy, sram_cen, init_busy);
    end
    @(negedge clk); drive_idle(); #1;
    test_sweep_from_zero("init_collision");
    // The sweep must have overwritten 0x1ff with INIT_VALUE.
    @(negedge clk); drive_read(9'h1FF); #1;
    @(negedge clk); drive_idle(); #1;
    for (int k = 1; k < LAT; k++) begin @(negedge clk); #1; end
    tests++;
    if (rsp_vld !== 1'b1 || rsp_data !== '0) begin
      fails++;
      $display("FAIL post_init_read: rsp_vld=%b rsp_data=%h, required 1 0", rsp_vld, rsp_data);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); drive_read(9'h002); #1;
    @(negedge clk); drive_idle(); #1;
    for (int k = 1; k < LAT; k++) begin @(negedge clk); #1; end
    tests++;
    if (rsp_vld !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_rsp: rsp_vld=%b, required 1", rsp_vld);
    end
    rst_b = 1'b0; #1;
    tests++;
    if (rsp_vld !== 1'b0 || rsp_data !== '0 || init_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_drops_rsp: rsp_vld=%b rsp_data=%h busy=%b, required 0 0 1", rsp_vld, rsp_data, init_busy);
    end
    @(negedge clk); #1;
    @(negedge clk); rst_b = 1'b1; #1;
    test_sweep_from_zero("reset_mid_read");
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk); init_req = 1'b1; #1;
    @(negedge clk); init_req = 1'b0; #1;
    for (int i = 0; i < 200; i++) begin @(negedge clk); #1; end
    tests++;
    if (sram_a !== 9'd200 || init_busy !== 1'b1) begin
      fails++;
      $display("FAIL sweep_at_200: a=%h busy=%b, required c8 1", sram_a, init_busy);
    end
    // init_req inside a sweep is ignored: the count keeps going.
    init_req = 1'b1;
    @(negedge clk); init_req = 1'b0; #1;
    tests++;
    if (sram_a !== 9'd201) begin
      fails++;
      $display("FAIL init_req_ignored: a=%h, required c9", sram_a);
    end
    rst_b = 1'b0; #1;
    tests++;
    if (sram_a !== '0 || sram_cen !== 1'b0 || init_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_sweep: a=%h cen=%b busy=%b, required 0 0 1", sram_a, sram_cen, init_busy);
    end
    @(negedge clk); rst_b = 1'b1; #1;
    test_sweep_from_zero("reset_mid_sweep");
  endtask

  initial begin
    rst_b     = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    drive_idle();
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_init_collision();
    test_reset_mid_read();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pa_spsram_512x38_ctrl.md
# pa_spsram_512x38_ctrl

Access controller directly upstream of the LSU 512x38 single-port SRAM wrapper. It turns a valid/ready request interface into the macro's active-low CEN/GWEN/WEN strobes and captures read data into a response pulse. It also runs a hardware init sweep that writes INIT_VALUE to all 512 entries after reset or on demand. It is the only driver of the SRAM ports.

## Interface
- ADDR_WIDTH, 9, SRAM address width; depth = 2^ADDR_WIDTH
- DATA_WIDTH, 38, data and bit-mask width
- INIT_VALUE, 38'b0, word written to every entry during init
- forever_cpuclk  input  1  clock; the only clock
- cpurst_b  input  1  reset, asynchronous, active-low
- req_vld  input  1  request valid
- req_rdy  output  1  request accepted when req_vld & req_rdy
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  entry index
- req_wdata  input  DATA_WIDTH  write data
- req_wmask  input  DATA_WIDTH  active-high per-bit write enable
- rsp_vld  output  1  one-cycle read-data-valid pulse
- rsp_data  output  DATA_WIDTH  read data, meaningful only when rsp_vld=1
- init_req  input  1  pulse; starts an init sweep
- init_busy  output  1  high while the sweep runs
- sram_a  output  ADDR_WIDTH  SRAM address
- sram_cen  output  1  SRAM chip enable, active-low
- sram_gwen  output  1  SRAM global write enable, active-low
- sram_wen  output  DATA_WIDTH  SRAM per-bit write enable, active-low
- sram_d  output  DATA_WIDTH  SRAM write data
- sram_q  input  DATA_WIDTH  SRAM read data, valid one cycle after a read strobe

## Operation
- FSM states:
  - INIT: sweep counter cnt runs 0..2^ADDR_WIDTH-1. Each cycle drives cen=0, gwen=0, wen=all 0, a=cnt, d=INIT_VALUE. On cnt = max, go to IDLE next cycle; cnt wraps to 0.
  - IDLE: serve requests.
- Reset enters INIT with cnt=0, so every reset ends in a full sweep.
- IDLE -> INIT when init_req=1. init_req in INIT is ignored; the sweep does not restart.
- req_rdy = (state==IDLE) & ~init_req. When init_req and req_vld are both high, init wins and the request is not accepted.
- SRAM outputs are combinational from the current request or sweep state. They are not registered.
- Accepted write: cen=0, gwen=0, wen=~req_wmask, d=req_wdata, a=req_addr. No response.
- Write with req_wmask=0: cen=0, gwen=1, treated as a no-op access. No response.
- Accepted read: cen=0, gwen=1, wen=all 1, a=req_addr.
- Idle cycle, with no accepted request and not in INIT: cen=1, gwen=1, wen=all 1. a and d hold their last driven values so they do not toggle.
- Back-to-back requests are accepted every cycle. A read immediately after a write to the same address returns the new data, because the SRAM completed the write in the earlier cycle.
- init_busy = (state==INIT).

## Timing
- Reset values: req_rdy=0, init_busy=1, rsp_vld=0, rsp_data=0, sram_cen=0 (the sweep starts), sram_gwen=0, sram_wen=all 0, sram_a=0, sram_d=INIT_VALUE.
- Read latency (default build): a read accepted in cycle N gives rsp_vld=1 and rsp_data=sram_q in cycle N+1.
- rsp_vld is a single-cycle pulse with no back-pressure; the consumer must take the data.
- Sweep: 2^ADDR_WIDTH cycles (512 by default). req_rdy rises the cycle after the last sweep write.
- Reset asserted mid-read: the pending rsp_vld is dropped, with no pulse after reset.
- Reset asserted mid-sweep: the sweep restarts at cnt=0.

## Configuration
- PA_SPSRAM_CTRL_RDATA_FLOP_EN:
  - Defined: sram_q goes through one extra register before rsp_data. Read latency becomes 2 (rsp_vld in N+2). Reads in flight keep their pulses across an IDLE->INIT transition.
  - Undefined: latency 1 as above, with rsp_data taken straight from sram_q and no data flop.

## Test plan
- Reset release: cen=0 for exactly 512 cycles with a=0..511, gwen=0, d=0. Then init_busy=0 and req_rdy=1 in cycle 513.
- Write addr 0x1FF, data 0x3F_FFFF_FFFF, mask all 1, then read 0x1FF. Expect rsp_vld one cycle after the read (two with the macro) and rsp_data=0x3F_FFFF_FFFF.
- Partial write with mask 0x00_0000_00FF and data 0x12 to an entry holding 0x3F_FFFF_FF00. Expect sram_wen=0x3F_FFFF_FF00; a later read returns 0x3F_FFFF_FF12.
- req_vld and init_req high in the same cycle: expect no accept, a sweep starting at a=0, and no rsp_vld.
- Reset asserted at sweep cnt=200 and released: expect the sweep to restart at a=0 and last 512 cycles.
- Reads to 0,1,2 on consecutive cycles: expect three consecutive rsp_vld pulses carrying the data of entries 0,1,2 in order.
